// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS requests (add/sub/and/or/slt/lw/sw/beq) into 32-bit words
// and streams them out through a small valid/ready FIFO.
module mips_instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [CNT_W-1:0] emit_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpSlt = 4'd4;
  localparam logic [3:0] OpLw  = 4'd5;
  localparam logic [3:0] OpSw  = 4'd6;
  localparam logic [3:0] OpBeq = 4'd7;

  logic [31:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [31:0]      head_q, head_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept, push, pop;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_op)
      OpAdd:   enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      OpSub:   enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      OpAnd:   enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      OpOr:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      OpSlt:   enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      OpLw:    enc_word = {6'h23, in_rs, in_rt, in_imm};
      OpSw:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
      OpBeq:   enc_word = {6'h04, in_rs, in_rt, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (occ_q != DepthOcc);
  assign out_valid = (occ_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    head_d     = head_q;
    err_d      = err_q;
    emit_cnt_d = emit_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      emit_cnt_d = emit_cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
    if (accept && !enc_legal) begin
      err_d = 1'b1;
    end

    // The head register tracks the next word to present; it holds its last value once empty.
    if (pop && occ_q > OccW'(1)) begin
      head_d = mem_q[rd_ptr_q + PtrW'(1)];
    end else if (push && (occ_q == '0 || (pop && occ_q == OccW'(1)))) begin
      head_d = enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      err_q      <= 1'b0;
      emit_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      err_q      <= err_d;
      emit_cnt_q <= emit_cnt_d;
    end
  end

  assign out_instr = head_q;
  assign err       = err_q;
  assign emit_cnt  = emit_cnt_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: encodings, ordering, backpressure, illegal ops, reset.
module tb_mips_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [15:0] emit_cnt;

  int checks;
  int errors;

  mips_instr_encoder #(
    .DEPTH(4),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rs    (in_rs),
    .in_rt    (in_rt),
    .in_rd    (in_rd),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .err      (err),
    .emit_cnt (emit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one rising edge.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm);
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 4'd0;
    in_rs     = 5'd0;
    in_rt     = 5'd0;
    in_rd     = 5'd0;
    in_imm    = 16'h0;
    out_ready = 1'b0;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_emit_cnt", 32'(emit_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // ADD with zero-latency output
    out_ready = 1'b1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    check("add_valid", 32'(out_valid), 32'h1);
    check("add_word", out_instr, 32'h0022_1820);
    check("add_cnt0", 32'(emit_cnt), 32'h0);
    step();
    check("add_cnt1", 32'(emit_cnt), 32'h1);
    check("add_empty", 32'(out_valid), 32'h0);
    check("add_hold", out_instr, 32'h0022_1820);

    // LW then SW, ordered
    out_ready = 1'b0;
    send(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004);
    check("lw_word", out_instr, 32'h8FA8_0004);
    send(4'd6, 5'd0, 5'd9, 5'd0, 16'h0010);
    check("lw_stable", out_instr, 32'h8FA8_0004);
    out_ready = 1'b1;
    step();
    check("sw_word", out_instr, 32'hAC09_0010);
    check("sw_cnt", 32'(emit_cnt), 32'h2);
    step();
    check("lwsw_cnt", 32'(emit_cnt), 32'h3);
    check("lwsw_empty", 32'(out_valid), 32'h0);

    // BEQ (rd ignored) then SLT, push and pop on the same edge
    send(4'd7, 5'd4, 5'd5, 5'd31, 16'hFFFF);
    check("beq_word", out_instr, 32'h1085_FFFF);
    send(4'd4, 5'd4, 5'd5, 5'd6, 16'h1234);
    check("slt_word", out_instr, 32'h0085_302A);
    check("slt_valid", 32'(out_valid), 32'h1);
    check("beq_cnt", 32'(emit_cnt), 32'h4);
    step();
    check("slt_cnt", 32'(emit_cnt), 32'h5);
    check("slt_empty", 32'(out_valid), 32'h0);

    // Backpressure: fill, then attempt a fifth request
    out_ready = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd1, 16'h0);
    send(4'd0, 5'd1, 5'd2, 5'd2, 16'h0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    check("bp_ready_3", 32'(in_ready), 32'h1);
    send(4'd0, 5'd1, 5'd2, 5'd4, 16'h0);
    check("bp_full", 32'(in_ready), 32'h0);
    send(4'd0, 5'd1, 5'd2, 5'd5, 16'h0);
    check("bp_still_full", 32'(in_ready), 32'h0);
    check("bp_head_stable", out_instr, 32'h0022_0820);
    out_ready = 1'b1;
    #1;
    check("bp_full_pop_ready", 32'(in_ready), 32'h0);
    step();
    check("drain_w2", out_instr, 32'h0022_1020);
    check("drain_ready", 32'(in_ready), 32'h1);
    step();
    check("drain_w3", out_instr, 32'h0022_1820);
    step();
    check("drain_w4", out_instr, 32'h0022_2020);
    check("drain_cnt", 32'(emit_cnt), 32'h8);
    step();
    check("drain_empty", 32'(out_valid), 32'h0);
    check("drain_cnt_end", 32'(emit_cnt), 32'h9);

    // Illegal op between two ADDs
    out_ready = 1'b0;
    check("pre_err", 32'(err), 32'h0);
    send(4'd0, 5'd1, 5'd2, 5'd1, 16'h0);
    send(4'd9, 5'd7, 5'd7, 5'd7, 16'h7777);
    check("ill_err", 32'(err), 32'h1);
    send(4'd0, 5'd1, 5'd2, 5'd2, 16'h0);
    out_ready = 1'b1;
    step();
    check("ill_second", out_instr, 32'h0022_1020);
    check("ill_cnt", 32'(emit_cnt), 32'd10);
    step();
    check("ill_empty", 32'(out_valid), 32'h0);
    check("ill_cnt_end", 32'(emit_cnt), 32'd11);
    check("err_sticky", 32'(err), 32'h1);

    // Reset with three words buffered
    out_ready = 1'b0;
    send(4'd1, 5'd3, 5'd3, 5'd3, 16'h0);
    send(4'd2, 5'd3, 5'd3, 5'd3, 16'h0);
    send(4'd3, 5'd3, 5'd3, 5'd3, 16'h0);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_cnt", 32'(emit_cnt), 32'h0);
    check("mid_rst_instr", out_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    check("post_rst_word", out_instr, 32'h0022_1820);
    step();
    check("post_rst_empty", 32'(out_valid), 32'h0);
    check("post_rst_cnt", 32'(emit_cnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
